// File: rtl/bus_disp_pkg.sv
// Shared definitions for the bus dispatcher: FSM states, frame field offsets
// and the error-counter width.
package bus_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } disp_state_e;

  localparam int ERR_CNT_W    = 8;
  localparam int FRM_OPID_LSB = 0;

  // Frame layout from LSB up: op_id, write data, write/read flag, register address.
  function automatic int frm_data_lsb(input int op_id_w);
    return op_id_w;
  endfunction

  function automatic int frm_wr_bit(input int op_id_w, input int w_width);
    return op_id_w + w_width;
  endfunction

  function automatic int frm_reg_lsb(input int op_id_w, input int w_width);
    return op_id_w + w_width + 1;
  endfunction

endpackage

// File: rtl/bus_disp_decode.sv
// Combinational switch-index decoder: one-hot target mask, in-range and broadcast flags.
// Broadcast on the all-ones index exists only when BUS_DISP_BCAST_EN is defined.
module bus_disp_decode
  import bus_disp_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int SW_ADDR_W   = 3
) (
  input  logic [SW_ADDR_W-1:0]   i_idx,
  output logic [NUM_SW_INST-1:0] o_mask,
  output logic                   o_in_range,
  output logic                   o_bcast
);

  localparam logic [SW_ADDR_W:0] NUM_L = (SW_ADDR_W+1)'(NUM_SW_INST);

  logic                   w_all_ones;
  logic [NUM_SW_INST-1:0] w_onehot;

`ifdef BUS_DISP_BCAST_EN
  assign w_all_ones = &i_idx;
`else
  assign w_all_ones = 1'b0;
`endif

  // One-hot decode of the switch index; out-of-range indices give an all-zero mask.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      w_onehot[i] = (i_idx == SW_ADDR_W'(i));
    end
  end

  // Broadcast overrides the ordinary index meaning, even when all-ones is a valid index.
  assign o_bcast    = w_all_ones;
  assign o_in_range = !w_all_ones && ({1'b0, i_idx} < NUM_L);
  assign o_mask     = w_all_ones ? {NUM_SW_INST{1'b1}} : w_onehot;

endmodule

// File: rtl/bus_dispatch_unit.sv
// bus_dispatch_unit: packs host register requests into frames and steers each to its
// switch FIFO, with back-pressure stalls and address-error counting. Macro: BUS_DISP_BCAST_EN.
module bus_dispatch_unit
  import bus_disp_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int SW_ADDR_W   = 3,
  parameter int REG_ADDR_W  = 5,
  parameter int W_WIDTH     = 8,
  parameter int OP_ID_W     = 8,
  parameter int FRAME_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en_in,
  input  logic                          valid,
  output logic                          ready,
  input  logic                          wr_rd_op,
  input  logic [OP_ID_W-1:0]            op_id,
  input  logic [SW_ADDR_W+REG_ADDR_W-1:0] addr_in,
  input  logic [W_WIDTH-1:0]            wr_data_in,
  input  logic [NUM_SW_INST-1:0]        fifo_full,
  output logic [FRAME_WIDTH-1:0]        frame_out,
  output logic [NUM_SW_INST-1:0]        fifo_wr_en,
  output logic                          addr_err,
  output logic [ERR_CNT_W-1:0]          err_cnt
);

  localparam int DATA_LSB = frm_data_lsb(OP_ID_W);
  localparam int WR_BIT   = frm_wr_bit(OP_ID_W, W_WIDTH);
  localparam int REG_LSB  = frm_reg_lsb(OP_ID_W, W_WIDTH);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

  disp_state_e            r_state;
  logic                   r_ready;
  logic [FRAME_WIDTH-1:0] r_frame;
  logic [NUM_SW_INST-1:0] r_wr_en;
  logic                   r_addr_err;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic [FRAME_WIDTH-1:0] r_hold_frame;
  logic [NUM_SW_INST-1:0] r_hold_mask;

  logic [SW_ADDR_W-1:0]   w_idx;
  logic [REG_ADDR_W-1:0]  w_reg_addr;
  logic [FRAME_WIDTH-1:0] w_frame;
  logic [NUM_SW_INST-1:0] w_dec_mask;
  logic                   w_dec_in_range;
  logic                   w_dec_bcast;
  logic                   w_target_ok;
  logic                   w_full_hit;
  logic                   w_hold_clear;

  assign w_idx      = addr_in[SW_ADDR_W+REG_ADDR_W-1:REG_ADDR_W];
  assign w_reg_addr = addr_in[REG_ADDR_W-1:0];

  bus_disp_decode #(
    .NUM_SW_INST (NUM_SW_INST),
    .SW_ADDR_W   (SW_ADDR_W)
  ) u_decode (
    .i_idx      (w_idx),
    .o_mask     (w_dec_mask),
    .o_in_range (w_dec_in_range),
    .o_bcast    (w_dec_bcast)
  );

  // Pack the request fields into a zero-padded frame.
  always_comb begin
    w_frame                             = '0;
    w_frame[FRM_OPID_LSB +: OP_ID_W]    = op_id;
    w_frame[DATA_LSB +: W_WIDTH]        = wr_data_in;
    w_frame[WR_BIT]                     = wr_rd_op;
    w_frame[REG_LSB +: REG_ADDR_W]      = w_reg_addr;
  end

  // A broadcast mask covers every FIFO, so any full flag blocks it.
  assign w_target_ok  = w_dec_in_range || w_dec_bcast;
  assign w_full_hit   = |(fifo_full & w_dec_mask);
  assign w_hold_clear = ~|(fifo_full & r_hold_mask);

  // Dispatcher FSM with registered handshake, frame, write-enable and error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ready      <= 1'b0;
      r_frame      <= '0;
      r_wr_en      <= '0;
      r_addr_err   <= 1'b0;
      r_err_cnt    <= '0;
      r_hold_frame <= '0;
      r_hold_mask  <= '0;
    end else begin
      r_frame    <= '0;
      r_wr_en    <= '0;
      r_addr_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en_in) begin
            r_state <= ACTIVE;
            r_ready <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_ready <= 1'b0;
          end
        end
        ACTIVE: begin
          if (valid) begin
            if (!w_target_ok) begin
              r_addr_err <= 1'b1;
              r_err_cnt  <= (r_err_cnt == ERR_MAX) ? r_err_cnt : r_err_cnt + ERR_CNT_W'(1);
              r_state    <= ACTIVE;
              r_ready    <= 1'b1;
            end else if (w_full_hit) begin
              r_hold_frame <= w_frame;
              r_hold_mask  <= w_dec_mask;
              r_state      <= STALL;
              r_ready      <= 1'b0;
            end else begin
              r_frame <= w_frame;
              r_wr_en <= w_dec_mask;
              r_state <= ACTIVE;
              r_ready <= 1'b1;
            end
          end else if (!en_in) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
          end else begin
            r_state <= ACTIVE;
            r_ready <= 1'b1;
          end
        end
        STALL: begin
          // A held frame is always delivered; en_in only picks the state afterwards.
          if (w_hold_clear) begin
            r_frame <= r_hold_frame;
            r_wr_en <= r_hold_mask;
            r_state <= en_in ? ACTIVE : IDLE;
            r_ready <= en_in;
          end else begin
            r_state <= STALL;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign frame_out  = r_frame;
  assign fifo_wr_en = r_wr_en;
  assign addr_err   = r_addr_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_bus_dispatch_unit.sv
// Directed bench for bus_dispatch_unit: a request-level reference model checked every
// negedge, plus hand-computed literal expectations. Honors BUS_DISP_BCAST_EN.
module tb_bus_dispatch_unit;

`ifdef BUS_DISP_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_in = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic        wr_rd_op = 1'b0;
  logic [7:0]  op_id = 8'h00;
  logic [7:0]  addr_in = 8'h00;
  logic [7:0]  wr_data_in = 8'h00;
  logic [4:0]  fifo_full = 5'b00000;
  logic [31:0] frame_out;
  logic [4:0]  fifo_wr_en;
  logic        addr_err;
  logic [7:0]  err_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  bus_dispatch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_in      (en_in),
    .valid      (valid),
    .ready      (ready),
    .wr_rd_op   (wr_rd_op),
    .op_id      (op_id),
    .addr_in    (addr_in),
    .wr_data_in (wr_data_in),
    .fifo_full  (fifo_full),
    .frame_out  (frame_out),
    .fifo_wr_en (fifo_wr_en),
    .addr_err   (addr_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request-level view (dispatcher on/off, one pending frame).
  bit          m_on = 1'b0;
  bit          m_held = 1'b0;
  logic [4:0]  m_hmask = 5'b00000;
  logic [31:0] m_hframe = 32'h0;
  logic [4:0]  e_wr = 5'b00000;
  logic [31:0] e_frame = 32'h0;
  logic        e_err = 1'b0;
  int          e_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    int          idx;
    logic [4:0]  mask;
    logic [31:0] frame;
    if (!rst_n) begin
      m_on = 1'b0; m_held = 1'b0; e_wr = 5'b00000; e_frame = 32'h0; e_err = 1'b0; e_cnt = 0;
    end else begin
      e_wr = 5'b00000; e_frame = 32'h0; e_err = 1'b0;
      if (m_held) begin
        if ((fifo_full & m_hmask) == 5'b00000) begin
          e_wr = m_hmask; e_frame = m_hframe; m_held = 1'b0; m_on = en_in;
        end
      end else if (!m_on) begin
        m_on = en_in;
      end else if (valid) begin
        idx   = int'(addr_in) / 32;
        frame = (32'(addr_in % 8'd32) * 32'd131072) + (32'(wr_rd_op) * 32'd65536)
              + (32'(wr_data_in) * 32'd256) + 32'(op_id);
        if (BCAST && idx == 7) mask = 5'b11111;
        else if (idx < 5) mask = 5'(1 << idx);
        else mask = 5'b00000;
        if (mask == 5'b00000) begin
          e_err = 1'b1;
          if (e_cnt < 255) e_cnt = e_cnt + 1;
        end else if ((fifo_full & mask) != 5'b00000) begin
          m_held = 1'b1; m_hmask = mask; m_hframe = frame;
        end else begin
          e_wr = mask; e_frame = frame;
        end
      end else begin
        m_on = en_in;
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("m_ready",    32'(ready),      32'(m_on && !m_held));
    check("m_wr_en",    32'(fifo_wr_en), 32'(e_wr));
    check("m_frame",    frame_out,       e_frame);
    check("m_addr_err", 32'(addr_err),   32'(e_err));
    check("m_err_cnt",  32'(err_cnt),    32'(e_cnt));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic req(input logic wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] o);
    valid = 1'b1; wr_rd_op = wr; addr_in = a; wr_data_in = d; op_id = o;
  endtask

  logic [7:0] b2b_addr [4] = '{8'h00, 8'h21, 8'h42, 8'h85};
  logic [4:0] b2b_exp  [4] = '{5'b00001, 5'b00010, 5'b00100, 5'b10000};

  initial begin
    repeat (3) step();
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_frame", frame_out, 32'h0);
    check("rst_cnt", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    step();
    en_in = 1'b1;
    step();
    check("ready_up", 32'(ready), 32'h1);

    req(1'b1, 8'h43, 8'hA5, 8'h11);
    step();
    valid = 1'b0;
    check("wr_0x43", 32'(fifo_wr_en), 32'h04);
    check("frame_0x43", frame_out, 32'h0007_A511);

    for (int i = 0; i < 4; i++) begin
      req(1'b0, b2b_addr[i], 8'h3C, 8'h7E);
      step();
      check("b2b_wr", 32'(fifo_wr_en), 32'(b2b_exp[i]));
      check("b2b_ready", 32'(ready), 32'h1);
    end
    valid = 1'b0;
    check("read_frame", frame_out, 32'h000A_3C7E);
    step();

    req(1'b1, 8'hA0, 8'h01, 8'h02);
    step();
    valid = 1'b0;
    check("bad_err", 32'(addr_err), 32'h1);
    check("bad_wr", 32'(fifo_wr_en), 32'h0);
    check("bad_cnt", 32'(err_cnt), 32'h1);
    step();
    req(1'b1, 8'hC3, 8'h01, 8'h02);
    repeat (300) step();
    valid = 1'b0;
    step();
    check("cnt_sat", 32'(err_cnt), 32'd255);

    fifo_full = 5'b00010;
    req(1'b1, 8'h2A, 8'h5C, 8'h33);
    step();
    valid = 1'b0;
    repeat (3) begin
      check("stall_ready", 32'(ready), 32'h0);
      check("stall_wr", 32'(fifo_wr_en), 32'h0);
      step();
    end
    fifo_full = 5'b00000;
    step();
    check("rel_wr", 32'(fifo_wr_en), 32'h02);
    check("rel_frame", frame_out, 32'h0015_5C33);
    check("rel_ready", 32'(ready), 32'h1);

    fifo_full = 5'b00100;
    req(1'b0, 8'h41, 8'h00, 8'h99);
    step();
    valid = 1'b0; en_in = 1'b0;
    repeat (2) step();
    fifo_full = 5'b00000;
    step();
    check("en0_wr", 32'(fifo_wr_en), 32'h04);
    check("en0_ready", 32'(ready), 32'h0);
    en_in = 1'b1;
    step();

    req(1'b1, 8'hE1, 8'hBB, 8'h01);
    step();
    valid = 1'b0;
    check("bc_wr", 32'(fifo_wr_en), BCAST ? 32'h1F : 32'h0);
    check("bc_err", 32'(addr_err), BCAST ? 32'h0 : 32'h1);
    fifo_full = 5'b01000;
    req(1'b1, 8'hE2, 8'hCC, 8'h02);
    step();
    valid = 1'b0;
    repeat (2) step();
    fifo_full = 5'b00000;
    step();
    check("bc_rel_wr", 32'(fifo_wr_en), BCAST ? 32'h1F : 32'h0);
    step();

    fifo_full = 5'b00001;
    req(1'b1, 8'h01, 8'h77, 8'h44);
    step();
    valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'h0);
    check("rst_mid_wr", 32'(fifo_wr_en), 32'h0);
    check("rst_mid_frame", frame_out, 32'h0);
    check("rst_mid_err", 32'(addr_err), 32'h0);
    check("rst_mid_cnt", 32'(err_cnt), 32'h0);
    fifo_full = 5'b00000;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check("post_rst_wr", 32'(fifo_wr_en), 32'h0);
    check("post_rst_frame", frame_out, 32'h0);
    step();
    check("post_rst_ready", 32'(ready), 32'h1);
    check("post_rst_wr2", 32'(fifo_wr_en), 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
